// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stack_pkg
// Purpose : Opcode, result-code and FSM state types shared by the stack block.
// Rev     : 1.0  initial release
// ============================================================================
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_DROP = 3'd4,
    OP_SWAP = 3'd5,
    OP_PEEK = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_ILL   = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WAIT = 3'd3,
    S_WR1  = 3'd4,
    S_WR2  = 3'd5,
    S_RESP = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stack_ctrl
// Purpose : Stack pointer owner and command sequencer for the LIFO datapath.
//           Define STACK_CTRL_ERRCNT_EN to build the saturating error counter.
// Rev     : 1.0  initial release
// ============================================================================
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [PTR_W-1:0] stk_pointer,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      err_cnt
);

  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] C_TWO   = PTR_W'(2);

  state_e           r_state;
  op_e              r_op;
  logic [PTR_W-1:0] r_sp;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              w_op;
  err_e             w_err;

  assign w_op      = op_e'(cmd_op);
  assign cmd_ready = (r_state == S_IDLE);
  assign count     = r_sp;
  assign full      = (r_sp == C_DEPTH);
  assign empty     = (r_sp == '0);

  // Write data comes from the captured A/B registers, gated to zero when idle
  assign stk_data_in = !stk_push ? '0 : (r_state == S_WR2) ? r_b : r_a;

  always_comb begin
    w_err = ERR_OK;
    case (w_op)
      OP_PUSH:                   if (full) w_err = ERR_OVER;
      OP_DUP:                    if (full) w_err = ERR_OVER;
                                 else if (empty) w_err = ERR_UNDER;
      OP_POP, OP_PEEK, OP_DROP:  if (empty) w_err = ERR_UNDER;
      OP_SWAP:                   if (r_sp < C_TWO) w_err = ERR_UNDER;
      OP_ILL:                    w_err = ERR_ILL;
      default:                   w_err = ERR_OK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_sp        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= ERR_OK;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_pointer <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op <= w_op;
            if (w_err != ERR_OK || w_op == OP_NOP || w_op == OP_DROP) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= w_err;
              if (w_err == ERR_OK && w_op == OP_DROP) r_sp <= r_sp - C_ONE;
            end else if (w_op == OP_PUSH) begin
              r_state     <= S_WR1;
              stk_push    <= 1'b1;
              stk_pointer <= r_sp;
              r_a         <= cmd_data;
            end else begin
              r_state     <= S_RD1;
              stk_pop     <= 1'b1;
              stk_pointer <= r_sp;
            end
          end
        end
        S_RD1: begin
          if (r_op == OP_SWAP) begin
            r_state     <= S_RD2;
            stk_pop     <= 1'b1;
            stk_pointer <= r_sp - C_ONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RD2: begin
          // Old top arrives now; the second pop's data lands during WR1
          r_a         <= stk_data_out;
          r_state     <= S_WR1;
          stk_push    <= 1'b1;
          stk_pointer <= r_sp - C_TWO;
        end
        S_WAIT: begin
          r_a <= stk_data_out;
          if (r_op == OP_DUP) begin
            r_state     <= S_WR1;
            stk_push    <= 1'b1;
            stk_pointer <= r_sp;
          end else begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= stk_data_out;
            if (r_op == OP_POP) r_sp <= r_sp - C_ONE;
          end
        end
        S_WR1: begin
          if (r_op == OP_SWAP) begin
            r_b         <= stk_data_out;
            r_state     <= S_WR2;
            stk_push    <= 1'b1;
            stk_pointer <= r_sp - C_ONE;
          end else begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            r_sp      <= r_sp + C_ONE;
          end
        end
        S_WR2: begin
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STACK_CTRL_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (rsp_valid && rsp_err != ERR_OK && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stack_ctrl
// Purpose : Scoreboard bench for stack_ctrl with a behavioural storage peer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
  logic             stk_push;
  logic             stk_pop;
  logic [PTR_W-1:0] stk_pointer;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out = '0;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic [15:0]      err_cnt;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_pointer(stk_pointer), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .count(count), .full(full), .empty(empty),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Storage peer: push writes entry p, pop returns entry p-1 next cycle
  logic [WIDTH-1:0] mem [0:7];
  always @(posedge clk) begin
    if (stk_push) mem[stk_pointer] <= stk_data_in;
    if (stk_pop) stk_data_out <= mem[stk_pointer - 3'd1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       e;
    int               c;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic watch = 1'b0;
  logic strobe_seen = 1'b0;
  logic both_seen = 1'b0;

`ifdef STACK_CTRL_ERRCNT_EN
  localparam logic [15:0] EXP_ERRS = 16'd2;
`else
  localparam logic [15:0] EXP_ERRS = 16'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stk_push && stk_pop) both_seen = 1'b1;
        if (watch && (stk_push || stk_pop)) strobe_seen = 1'b1;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 data=%0h err=%0d, required none", rsp_data, rsp_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.d));
            chk("rsp_err", 32'(rsp_err), 32'(e.e));
            chk("rsp_cycle", cyc, e.c);
          end
        end
      end
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got cmd_ready=0, required 1");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d,
                       input logic [7:0] ed, input logic [1:0] ee, input int lat);
    int t = 0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    exp_q.push_back('{d: ed, e: ee, c: cyc + lat});
    @(negedge clk);
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got no response, required one for op %0d", op);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    fork
      monitor();
    join_none

    do_reset();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_strobes", {stk_push, stk_pop}, 0);
    chk("rst_pointer", 32'(stk_pointer), 0);
    chk("rst_data_in", 32'(stk_data_in), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full_empty", {full, empty}, 32'b01);
    chk("rst_err_cnt", 32'(err_cnt), 0);

    // Fill to DEPTH, then overflow
    issue(3'd1, 8'h11, 8'h00, 2'd0, 2);
    issue(3'd1, 8'h22, 8'h00, 2'd0, 2);
    issue(3'd1, 8'h33, 8'h00, 2'd0, 2);
    issue(3'd1, 8'h44, 8'h00, 2'd0, 2);
    issue(3'd1, 8'h55, 8'h00, 2'd2, 1);
    chk("full_count", 32'(count), 4);
    chk("full_flag", 32'(full), 1);

    issue(3'd2, 8'h00, 8'h44, 2'd0, 3);
    chk("pop_count", 32'(count), 3);

    // [11,22,33] swap -> [11,33,22]
    issue(3'd5, 8'h00, 8'h00, 2'd0, 5);
    issue(3'd2, 8'h00, 8'h22, 2'd0, 3);
    issue(3'd2, 8'h00, 8'h33, 2'd0, 3);
    chk("swap_count", 32'(count), 1);

    issue(3'd3, 8'h00, 8'h00, 2'd0, 4);
    issue(3'd6, 8'h00, 8'h11, 2'd0, 3);
    chk("dup_count", 32'(count), 2);
    issue(3'd4, 8'h00, 8'h00, 2'd0, 1);
    issue(3'd4, 8'h00, 8'h00, 2'd0, 1);
    chk("drop_empty", 32'(empty), 1);
    issue(3'd5, 8'h00, 8'h00, 2'd1, 1);
    issue(3'd0, 8'h00, 8'h00, 2'd0, 1);
    repeat (2) @(negedge clk);
    chk("err_cnt_a", 32'(err_cnt), 32'(EXP_ERRS));

    // Illegal op and underflow from a fresh reset: no stack strobes
    do_reset();
    chk("err_cnt_rst", 32'(err_cnt), 0);
    watch = 1'b1;
    issue(3'd7, 8'hAB, 8'h00, 2'd3, 1);
    issue(3'd2, 8'h00, 8'h00, 2'd1, 1);
    repeat (2) @(negedge clk);
    watch = 1'b0;
    chk("err_no_strobe", 32'(strobe_seen), 0);
    chk("err_cnt_b", 32'(err_cnt), 32'(EXP_ERRS));
    chk("err_count", 32'(count), 0);

    // Reset during the WR1 cycle of a SWAP
    issue(3'd1, 8'hAA, 8'h00, 2'd0, 2);
    issue(3'd1, 8'hBB, 8'h00, 2'd0, 2);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = 8'h00;
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("swap_wr1_push", 32'(stk_push), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_count", 32'(count), 0);
    chk("abort_empty", 32'(empty), 1);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("never_both_strobes", 32'(both_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
